// File: rtl/cmult_rr_scheduler.sv
// Round-robin front end for one shared pipelined complex multiplier.
// Grants one requester per cycle, tags each issue and routes results back one-hot.
module cmult_rr_scheduler #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DW      = 18,
    parameter int unsigned MUL_LAT = 1
) (
    input  logic                  clk_i,
    input  logic                  srst_i,
    input  logic [NUM_REQ-1:0]    req_valid_i,
    output logic [NUM_REQ-1:0]    req_ready_o,
    input  logic [NUM_REQ*DW-1:0] req_a_i_i,
    input  logic [NUM_REQ*DW-1:0] req_a_q_i,
    input  logic [NUM_REQ*DW-1:0] req_b_i_i,
    input  logic [NUM_REQ*DW-1:0] req_b_q_i,
    output logic [DW-1:0]         mul_a_i_o,
    output logic [DW-1:0]         mul_a_q_o,
    output logic [DW-1:0]         mul_b_i_o,
    output logic [DW-1:0]         mul_b_q_o,
    input  logic [2*DW:0]         mul_i_i,
    input  logic [2*DW:0]         mul_q_i,
    output logic [NUM_REQ-1:0]    res_valid_o,
    output logic [2*DW:0]         res_i_o,
    output logic [2*DW:0]         res_q_o,
    output logic                  busy_o
);

    localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned NS = MUL_LAT + 1;

    logic [IW-1:0] ptr;
    logic [IW-1:0] win;
    logic          found;
    logic          accept;
    int unsigned   idx;

    logic [NS-1:0] tag_vld;
    logic [IW-1:0] tag_idx [NS];

    // Rotating-priority search starting just after the last winner
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = (32'(ptr) + i + 32'd1) % NUM_REQ;
            if (!found && req_valid_i[idx]) begin
                found = 1'b1;
                win   = IW'(idx);
            end
        end
        accept      = found && !srst_i;
        req_ready_o = accept ? (NUM_REQ'(1) << win) : '0;
    end

    // Operand issue, tag pipeline and result return
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            ptr         <= IW'(NUM_REQ - 1);
            mul_a_i_o   <= '0;
            mul_a_q_o   <= '0;
            mul_b_i_o   <= '0;
            mul_b_q_o   <= '0;
            tag_vld     <= '0;
            for (int unsigned s = 0; s < NS; s++) begin
                tag_idx[s] <= '0;
            end
            res_valid_o <= '0;
            res_i_o     <= '0;
            res_q_o     <= '0;
            busy_o      <= 1'b0;
        end else begin
            if (accept) begin
                mul_a_i_o <= req_a_i_i[32'(win)*DW +: DW];
                mul_a_q_o <= req_a_q_i[32'(win)*DW +: DW];
                mul_b_i_o <= req_b_i_i[32'(win)*DW +: DW];
                mul_b_q_o <= req_b_q_i[32'(win)*DW +: DW];
                ptr       <= win;
            end
            tag_vld    <= {tag_vld[NS-2:0], accept};
            tag_idx[0] <= win;
            for (int unsigned s = 1; s < NS; s++) begin
                tag_idx[s] <= tag_idx[s-1];
            end
            if (tag_vld[NS-1]) begin
                res_i_o     <= mul_i_i;
                res_q_o     <= mul_q_i;
                res_valid_o <= NUM_REQ'(1) << tag_idx[NS-1];
            end else begin
                res_valid_o <= '0;
            end
            // Busy covers every tag still in flight after this edge
            busy_o <= |{tag_vld[NS-2:0], accept};
        end
    end

endmodule

// File: tb/tb_cmult_rr_scheduler.sv
// Scoreboard bench for cmult_rr_scheduler with behavioural multipliers at MUL_LAT 1 and 3.
module tb_cmult_rr_scheduler;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 18;
    localparam int unsigned RW = 2*DW+1;

    typedef struct {
        int                   idx;
        logic signed [RW-1:0] i;
        logic signed [RW-1:0] q;
        int                   due;
    } exp_t;

    logic clk = 1'b0;
    logic srst = 1'b1;
    always #5 clk = ~clk;

    // Main DUT, MUL_LAT = 1
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*DW-1:0] a_i = '0, a_q = '0, b_i = '0, b_q = '0;
    logic [DW-1:0]   m_ai, m_aq, m_bi, m_bq;
    logic [RW-1:0]   m_i, m_q;
    logic [N-1:0]    res_valid;
    logic [RW-1:0]   res_i, res_q;
    logic            busy;

    cmult_rr_scheduler #(.NUM_REQ(N), .DW(DW), .MUL_LAT(1)) dut (
        .clk_i(clk), .srst_i(srst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_a_i_i(a_i), .req_a_q_i(a_q), .req_b_i_i(b_i), .req_b_q_i(b_q),
        .mul_a_i_o(m_ai), .mul_a_q_o(m_aq), .mul_b_i_o(m_bi), .mul_b_q_o(m_bq),
        .mul_i_i(m_i), .mul_q_i(m_q),
        .res_valid_o(res_valid), .res_i_o(res_i), .res_q_o(res_q), .busy_o(busy)
    );

    // Second DUT, MUL_LAT = 3
    logic [N-1:0]    d3_valid = '0;
    logic [N-1:0]    d3_ready;
    logic [N*DW-1:0] d3_a_i = '0, d3_a_q = '0, d3_b_i = '0, d3_b_q = '0;
    logic [DW-1:0]   d3_ai, d3_aq, d3_bi, d3_bq;
    logic [RW-1:0]   d3_mi, d3_mq;
    logic [N-1:0]    d3_res_valid;
    logic [RW-1:0]   d3_res_i, d3_res_q;
    logic            d3_busy;

    cmult_rr_scheduler #(.NUM_REQ(N), .DW(DW), .MUL_LAT(3)) dut3 (
        .clk_i(clk), .srst_i(srst),
        .req_valid_i(d3_valid), .req_ready_o(d3_ready),
        .req_a_i_i(d3_a_i), .req_a_q_i(d3_a_q), .req_b_i_i(d3_b_i), .req_b_q_i(d3_b_q),
        .mul_a_i_o(d3_ai), .mul_a_q_o(d3_aq), .mul_b_i_o(d3_bi), .mul_b_q_o(d3_bq),
        .mul_i_i(d3_mi), .mul_q_i(d3_mq),
        .res_valid_o(d3_res_valid), .res_i_o(d3_res_i), .res_q_o(d3_res_q), .busy_o(d3_busy)
    );

    function automatic logic signed [RW-1:0] cmi(input logic signed [DW-1:0] ai, aq, bi, bq);
        logic signed [RW-1:0] p1, p2;
        p1 = ai * bi;
        p2 = aq * bq;
        return p1 - p2;
    endfunction

    function automatic logic signed [RW-1:0] cmq(input logic signed [DW-1:0] ai, aq, bi, bq);
        logic signed [RW-1:0] p1, p2;
        p1 = aq * bi;
        p2 = ai * bq;
        return p1 + p2;
    endfunction

    // Behavioural shared multipliers
    logic signed [RW-1:0] p1_i, p1_q;
    logic signed [RW-1:0] p3_i [3];
    logic signed [RW-1:0] p3_q [3];
    always @(posedge clk) begin
        p1_i    <= cmi(m_ai, m_aq, m_bi, m_bq);
        p1_q    <= cmq(m_ai, m_aq, m_bi, m_bq);
        p3_i[0] <= cmi(d3_ai, d3_aq, d3_bi, d3_bq);
        p3_q[0] <= cmq(d3_ai, d3_aq, d3_bi, d3_bq);
        p3_i[1] <= p3_i[0];
        p3_q[1] <= p3_q[0];
        p3_i[2] <= p3_i[1];
        p3_q[2] <= p3_q[1];
    end
    assign m_i   = p1_i;
    assign m_q   = p1_q;
    assign d3_mi = p3_i[2];
    assign d3_mq = p3_q[2];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    exp_t sb[$];

    logic signed [DW-1:0] op_ai [N];
    logic signed [DW-1:0] op_aq [N];
    logic signed [DW-1:0] op_bi [N];
    logic signed [DW-1:0] op_bq [N];

    task automatic check_eq(input string tag, input logic signed [63:0] got,
                            input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One cycle of stimulus; g is the expected winner (-1 for none)
    task automatic drive(input logic [N-1:0] v, input int g, input bit push);
        exp_t e;
        @(negedge clk);
        req_valid = v;
        for (int n = 0; n < int'(N); n++) begin
            a_i[n*DW +: DW] = op_ai[n];
            a_q[n*DW +: DW] = op_aq[n];
            b_i[n*DW +: DW] = op_bi[n];
            b_q[n*DW +: DW] = op_bq[n];
        end
        #1;
        check_eq("ready", req_ready, (g < 0) ? 0 : (1 << g));
        if (g >= 0 && push) begin
            e.idx = g;
            e.i   = cmi(op_ai[g], op_aq[g], op_bi[g], op_bq[g]);
            e.q   = cmq(op_ai[g], op_aq[g], op_bi[g], op_bq[g]);
            e.due = cyc + 3;
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 4; k++) drive('0, -1, 1'b0);
        check_eq("sb_empty", sb.size(), 0);
        check_eq("busy_idle", busy, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        srst = 1'b1;
        req_valid = '0;
        @(negedge clk);
        srst = 1'b0;
    endtask

    task automatic set_op(input int n, input int ai, input int aq, input int bi, input int bq);
        op_ai[n] = DW'(ai);
        op_aq[n] = DW'(aq);
        op_bi[n] = DW'(bi);
        op_bq[n] = DW'(bq);
    endtask

    // Result monitor: exactly the scoreboard head may strobe, on its due cycle
    always @(negedge clk) begin
        if (mon_en) begin
            logic [N-1:0] exp_v;
            exp_t e;
            exp_v = '0;
            if (sb.size() > 0 && sb[0].due == cyc) exp_v = N'(1) << sb[0].idx;
            check_eq("res_valid", res_valid, exp_v);
            if (exp_v != '0) begin
                e = sb.pop_front();
                check_eq("res_i", $signed(res_i), e.i);
                check_eq("res_q", $signed(res_q), e.q);
            end
        end
    end

    initial begin
        for (int n = 0; n < int'(N); n++) set_op(n, 0, 0, 0, 0);

        // Reset values, with requests present during reset
        repeat (2) @(negedge clk);
        req_valid = '1;
        #1;
        check_eq("rst_ready", req_ready, 0);
        check_eq("rst_res_valid", res_valid, 0);
        check_eq("rst_res_i", res_i, 0);
        check_eq("rst_res_q", res_q, 0);
        check_eq("rst_mul_ai", m_ai, 0);
        check_eq("rst_mul_bq", m_bq, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_d3_busy", d3_busy, 0);
        srst = 1'b0;
        req_valid = '0;
        mon_en = 1'b1;

        // Single uncontested stream from requester 0
        set_op(0, 3, 4, 5, -2);
        for (int k = 0; k < 6; k++) drive(4'b0001, 0, 1'b1);
        @(negedge clk);
        check_eq("busy_stream", busy, 1);
        req_valid = '0;
        drain();

        // All four requesters with distinct operands
        do_reset();
        for (int n = 0; n < int'(N); n++)
            set_op(n, 1000*(n+1), -11*(n+7), 300*n-500, 2*n+9);
        for (int k = 0; k < 8; k++) drive(4'b1111, k % 4, 1'b1);

        // Requesters 1 and 3, then 3 drops out
        for (int k = 0; k < 4; k++) drive(4'b1010, (k % 2 == 0) ? 1 : 3, 1'b1);
        for (int k = 0; k < 3; k++) drive(4'b0010, 1, 1'b1);
        drain();

        // Operand extremes
        set_op(2, -131072, -131072, -131072, -131072);
        drive(4'b0100, 2, 1'b1);
        set_op(2, 131071, -131072, 131071, 131071);
        drive(4'b0100, 2, 1'b1);
        drain();

        // Reset with operations in flight: only the first result escapes
        set_op(0, -7, 12, 33, -5);
        drive(4'b0001, 0, 1'b1);
        drive(4'b0001, 0, 1'b0);
        drive(4'b0001, 0, 1'b0);
        @(negedge clk);
        srst = 1'b1;
        req_valid = 4'b0101;
        #1;
        check_eq("rst_mid_ready", req_ready, 0);
        @(negedge clk);
        srst = 1'b0;
        req_valid = '0;
        #1;
        check_eq("rst_mid_busy", busy, 0);
        check_eq("rst_mid_res_i", res_i, 0);
        for (int k = 0; k < 3; k++) drive('0, -1, 1'b0);
        check_eq("rst_mid_busy2", busy, 0);
        set_op(2, 9, -9, 4, 6);
        drive(4'b0101, 0, 1'b1);
        drive(4'b0101, 2, 1'b1);
        drain();

        // MUL_LAT = 3 instance: single accept, four busy cycles, then one strobe
        @(negedge clk);
        d3_valid = 4'b0001;
        d3_a_i[DW-1:0] = DW'(3);
        d3_a_q[DW-1:0] = DW'(4);
        d3_b_i[DW-1:0] = DW'(5);
        d3_b_q[DW-1:0] = DW'(-2);
        #1;
        check_eq("d3_ready", d3_ready, 1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            d3_valid = '0;
            #1;
            check_eq("d3_busy_inflight", d3_busy, 1);
            check_eq("d3_res_valid_early", d3_res_valid, 0);
        end
        @(negedge clk);
        #1;
        check_eq("d3_res_valid", d3_res_valid, 1);
        check_eq("d3_res_i", $signed(d3_res_i), 23);
        check_eq("d3_res_q", $signed(d3_res_q), 14);
        check_eq("d3_busy_done", d3_busy, 0);
        @(negedge clk);
        #1;
        check_eq("d3_res_valid_once", d3_res_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
